// File: rtl/sobel_result_packer_if.sv
// Ready/valid stream carrying packed 128-bit result words with an end-of-frame tag.
interface sobel_result_packer_if;
    logic [127:0] data;
    logic         valid;
    logic         ready;
    logic         last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/sobel_result_packer.sv
// Packs one filter result byte per beat into 128-bit words, buffers them in a small
// FIFO and streams them out; overflow is flagged rather than back-pressured.
module sobel_result_packer #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [CNT_W-1:0]     i_frame_pixels,
    input  logic [127:0]         i_data_in,
    input  logic                 i_valid_in,
    sobel_result_packer_if.master m,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic [CNT_W-1:0]     o_pixel_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RUN        = 2'd1,
        FLUSH      = 2'd2,
        WAIT_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [CNT_W-1:0]      r_frame_pixels;
    logic [CNT_W-1:0]      r_pixel_count;
    logic [3:0]            r_idx;
    logic [127:0]          r_pack;
    logic [127:0]          r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_last;
    logic [PTR_W:0]        r_wptr;
    logic [PTR_W:0]        r_rptr;
    logic                  r_done;
    logic                  r_overflow;

    logic         w_empty;
    logic         w_full;
    logic         w_pop;
    logic         w_head_last;
    logic         w_beat;
    logic         w_final_byte;
    logic         w_push;
    logic         w_push_ok;
    logic         w_drop;
    logic         w_start_ok;
    logic         w_done_next;
    logic [127:0] w_word;
    logic         w_unused_data;

    // Upper lanes of the filter bus carry nothing this block needs.
    assign w_unused_data = ^i_data_in[127:8];

    assign w_empty      = (r_wptr == r_rptr);
    assign w_full       = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                          (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_pop        = !w_empty && m.ready;
    assign w_head_last  = r_fifo_last[r_rptr[PTR_W-1:0]];
    assign w_beat       = (r_state == RUN) && i_valid_in;
    assign w_final_byte = ((r_pixel_count + CNT_W'(1)) == r_frame_pixels);
    assign w_push       = w_beat && ((r_idx == 4'd15) || w_final_byte);
    assign w_word       = r_pack | ({120'd0, i_data_in[7:0]} << {r_idx, 3'b000});
    assign w_push_ok    = w_push && (!w_full || w_pop);
    assign w_drop       = w_push && w_full && !w_pop;
    assign w_start_ok   = (r_state == IDLE) && i_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (i_frame_pixels == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_next_state = RUN;
                    end
                end
            end
            RUN: begin
                if (w_beat && w_final_byte) begin
                    // A dropped final word can never be popped, so the frame ends here.
                    if (w_drop) begin
                        w_next_state = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_next_state = WAIT_DRAIN;
                    end
                end
            end
            WAIT_DRAIN: begin
                if (w_pop && w_head_last) begin
                    w_next_state = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_pixels <= '0;
            r_pixel_count  <= '0;
            r_idx          <= '0;
            r_pack         <= '0;
            r_fifo_last    <= '0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_done         <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (w_start_ok) begin
                r_frame_pixels <= i_frame_pixels;
                r_pixel_count  <= '0;
                r_idx          <= '0;
                r_pack         <= '0;
                r_overflow     <= 1'b0;
            end else if (w_beat) begin
                r_pixel_count <= r_pixel_count + CNT_W'(1);
                r_idx         <= r_idx + 4'd1;
                r_pack        <= w_push ? 128'd0 : w_word;
            end
            if (w_push_ok) begin
                r_fifo_last[r_wptr[PTR_W-1:0]] <= w_final_byte;
                r_wptr                         <= r_wptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo_data[r_wptr[PTR_W-1:0]] <= w_word;
        end
    end

    assign m.valid       = !w_empty;
    assign m.data        = w_empty ? 128'd0 : r_fifo_data[r_rptr[PTR_W-1:0]];
    assign m.last        = !w_empty && w_head_last;
    assign o_busy        = (r_state == RUN) || (r_state == WAIT_DRAIN);
    assign o_done        = r_done;
    assign o_overflow    = r_overflow;
    assign o_pixel_count = r_pixel_count;

endmodule

// File: tb/tb_sobel_result_packer.sv
// Randomized bench for sobel_result_packer: a byte-queue reference model predicts
// every output each cycle, plus directed checks on the packed words seen downstream.
module tb_sobel_result_packer;

    localparam int DEPTH = 8;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] framePixels;
    logic [127:0]  dataIn;
    logic          validIn;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [CW-1:0] pixelCount;

    sobel_result_packer_if mIf();

    sobel_result_packer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (start),
        .i_frame_pixels (framePixels),
        .i_data_in      (dataIn),
        .i_valid_in     (validIn),
        .m              (mIf),
        .o_busy         (busy),
        .o_done         (done),
        .o_overflow     (overflow),
        .o_pixel_count  (pixelCount)
    );

    always #5 clk = ~clk;

    int numVectors = 0;
    int numFails   = 0;
    bit checkEn    = 1'b0;
    bit sawValid   = 1'b0;
    int readyMode  = 0;

    logic [7:0]   txBytes [256];
    logic [127:0] rxData [$];
    bit           rxLast [$];
    logic [127:0] savedData [$];
    bit           savedLast [$];

    typedef struct {
        logic [127:0] data;
        bit           last;
    } word_t;

    word_t         modelQ [$];
    logic [7:0]    partial [$];
    int            modelPhase    = 0;
    bit            modelDone     = 1'b0;
    bit            modelOverflow = 1'b0;
    logic [CW-1:0] modelCount    = '0;
    logic [CW-1:0] modelFrame    = '0;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        numVectors++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] makeWord(input int base, input int n);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = txBytes[base + k];
        return w;
    endfunction

    function automatic logic [127:0] rxAt(input int k);
        return (k < rxData.size()) ? rxData[k] : 128'd0;
    endfunction

    function automatic bit rxLastAt(input int k);
        return (k < rxLast.size()) ? rxLast[k] : 1'b0;
    endfunction

    // Reference: frame bytes accumulate in a queue and become words of 16 (or the remainder).
    always @(posedge clk) begin : refModel
        bit    popNow;
        bit    popLast;
        bit    haveWord;
        bit    doneNow;
        int    prevPhase;
        word_t w;
        popNow = (modelQ.size() != 0) && (mIf.ready === 1'b1);
        if (rst) begin
            modelQ.delete();
            partial.delete();
            modelPhase    = 0;
            modelDone     = 1'b0;
            modelOverflow = 1'b0;
            modelCount    = '0;
            modelFrame    = '0;
        end else begin
            popLast   = popNow && modelQ[0].last;
            prevPhase = modelPhase;
            doneNow   = 1'b0;
            haveWord  = 1'b0;
            w.data    = '0;
            w.last    = 1'b0;
            if (modelPhase == 0 && start) begin
                modelFrame    = framePixels;
                modelCount    = '0;
                modelOverflow = 1'b0;
                partial.delete();
                if (framePixels == 0) doneNow = 1'b1;
                else modelPhase = 1;
            end else if (modelPhase == 1 && validIn) begin
                partial.push_back(dataIn[7:0]);
                modelCount = modelCount + 1;
                if (partial.size() == 16 || modelCount == modelFrame) begin
                    foreach (partial[k]) w.data[8*k +: 8] = partial[k];
                    w.last   = (modelCount == modelFrame);
                    haveWord = 1'b1;
                    partial.delete();
                    if (w.last) modelPhase = 2;
                end
            end
            if (popNow) void'(modelQ.pop_front());
            if (haveWord) begin
                if (modelQ.size() < DEPTH) begin
                    modelQ.push_back(w);
                end else begin
                    modelOverflow = 1'b1;
                    if (w.last) begin
                        modelPhase = 0;
                        doneNow    = 1'b1;
                    end
                end
            end
            if (prevPhase == 2 && popLast) begin
                modelPhase = 0;
                doneNow    = 1'b1;
            end
            modelDone = doneNow;
        end
    end

    always @(negedge clk) begin : cycleCheck
        bit           expValid;
        logic [127:0] expData;
        bit           expLast;
        if (checkEn) begin
            expValid = (modelQ.size() != 0);
            expData  = '0;
            expLast  = 1'b0;
            if (expValid) begin
                expData = modelQ[0].data;
                expLast = modelQ[0].last;
            end
            checkOutput("m_valid", mIf.valid, expValid);
            checkOutput("m_data", mIf.data, expData);
            checkOutput("m_last", mIf.last, expLast);
            checkOutput("busy", busy, modelPhase != 0);
            checkOutput("done", done, modelDone);
            checkOutput("overflow", overflow, modelOverflow);
            checkOutput("pixel_count", pixelCount, modelCount);
            if (mIf.valid) sawValid = 1'b1;
            if (mIf.valid && mIf.ready) begin
                rxData.push_back(mIf.data);
                rxLast.push_back(mIf.last);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       mIf.ready = 1'b0;
            1:       mIf.ready = 1'b1;
            default: mIf.ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic applyStimulus(input int fp, input int nBytes, input int gap, input int restartAt);
        @(posedge clk); #1;
        start       = 1'b1;
        framePixels = CW'(fp);
        validIn     = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < nBytes; i++) begin
            dataIn      = {$urandom, $urandom, $urandom, $urandom};
            dataIn[7:0] = txBytes[i];
            validIn     = 1'b1;
            if (i == restartAt) begin
                start       = 1'b1;
                framePixels = CW'(5);
            end
            @(posedge clk); #1;
            validIn = 1'b0;
            start   = 1'b0;
            for (int g = 1; g < gap; g++) begin
                dataIn = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk); #1;
            end
        end
        validIn = 1'b0;
        start   = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        while ((busy || mIf.valid) && n < maxCycles) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("idleReached", busy || mIf.valid, 1'b0);
    endtask

    task automatic clearRx();
        rxData.delete();
        rxLast.delete();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        validIn     = 1'b0;
        dataIn      = '0;
        framePixels = '0;
        mIf.ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("rst_valid", mIf.valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_count", pixelCount, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Gapless 32-byte frame, ascending bytes.
        for (int i = 0; i < 32; i++) txBytes[i] = 8'(i);
        readyMode = 1;
        clearRx();
        applyStimulus(32, 32, 1, -1);
        waitIdle(500);
        checkOutput("t1_words", rxData.size(), 2);
        checkOutput("t1_word0", rxAt(0), 128'h0f0e0d0c0b0a09080706050403020100);
        checkOutput("t1_last0", rxLastAt(0), 1'b0);
        checkOutput("t1_word1", rxAt(1), 128'h1f1e1d1c1b1a19181716151413121110);
        checkOutput("t1_last1", rxLastAt(1), 1'b1);
        checkOutput("t1_count", pixelCount, 32);

        // Partial final word.
        for (int i = 0; i < 20; i++) txBytes[i] = 8'(8'hA0 + i);
        clearRx();
        applyStimulus(20, 20, 1, -1);
        waitIdle(500);
        checkOutput("t2_words", rxData.size(), 2);
        checkOutput("t2_word0", rxAt(0), 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
        checkOutput("t2_word1", rxAt(1), 128'h000000000000000000000000B3B2B1B0);
        checkOutput("t2_last1", rxLastAt(1), 1'b1);

        // Overflow with the output stalled, then drain.
        for (int i = 0; i < 16 * (DEPTH + 2); i++) txBytes[i] = 8'($urandom);
        readyMode = 0;
        clearRx();
        applyStimulus(16 * (DEPTH + 2), 16 * (DEPTH + 2), 1, -1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("t3_overflow", overflow, 1'b1);
        checkOutput("t3_busy", busy, 1'b0);
        checkOutput("t3_valid", mIf.valid, 1'b1);
        @(posedge clk); #1;
        readyMode = 1;
        waitIdle(500);
        checkOutput("t3_words", rxData.size(), DEPTH);
        for (int k = 0; k < DEPTH; k++) begin
            checkOutput($sformatf("t3_word%0d", k), rxAt(k), makeWord(16 * k, 16));
            checkOutput($sformatf("t3_last%0d", k), rxLastAt(k), 1'b0);
        end

        // Gapless reference run, then gapped input with random stalls.
        for (int i = 0; i < 48; i++) txBytes[i] = 8'($urandom);
        readyMode = 1;
        clearRx();
        applyStimulus(48, 48, 1, -1);
        waitIdle(500);
        savedData = rxData;
        savedLast = rxLast;
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("t4_ref%0d", k), rxAt(k), makeWord(16 * k, 16));
        readyMode = 2;
        clearRx();
        applyStimulus(48, 48, 3, -1);
        waitIdle(1000);
        checkOutput("t4_words", rxData.size(), savedData.size());
        for (int k = 0; k < savedData.size(); k++) begin
            checkOutput($sformatf("t4_word%0d", k), rxAt(k), savedData[k]);
            checkOutput($sformatf("t4_last%0d", k), rxLastAt(k), savedLast[k]);
        end

        // Empty frame.
        readyMode = 1;
        sawValid  = 1'b0;
        applyStimulus(0, 0, 1, -1);
        @(negedge clk);
        checkOutput("t5_done", done, 1'b1);
        @(negedge clk);
        checkOutput("t5_doneEnd", done, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_noValid", sawValid, 1'b0);

        // Start while busy must not change the frame length.
        for (int i = 0; i < 16; i++) txBytes[i] = 8'($urandom);
        clearRx();
        applyStimulus(16, 16, 1, 5);
        waitIdle(500);
        checkOutput("t5_words", rxData.size(), 1);
        checkOutput("t5_word0", rxAt(0), makeWord(0, 16));
        checkOutput("t5_last0", rxLastAt(0), 1'b1);
        checkOutput("t5_count", pixelCount, 16);

        // Reset mid-frame, then a fresh 16-byte frame.
        for (int i = 0; i < 32; i++) txBytes[i] = 8'($urandom);
        readyMode = 2;
        applyStimulus(32, 10, 1, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t6_valid", mIf.valid, 1'b0);
        checkOutput("t6_data", mIf.data, 128'd0);
        checkOutput("t6_last", mIf.last, 1'b0);
        checkOutput("t6_busy", busy, 1'b0);
        checkOutput("t6_done", done, 1'b0);
        checkOutput("t6_overflow", overflow, 1'b0);
        checkOutput("t6_count", pixelCount, 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        readyMode = 1;
        for (int i = 0; i < 16; i++) txBytes[i] = 8'($urandom);
        clearRx();
        applyStimulus(16, 16, 1, -1);
        waitIdle(500);
        checkOutput("t6_words", rxData.size(), 1);
        checkOutput("t6_word0", rxAt(0), makeWord(0, 16));
        checkOutput("t6_last0", rxLastAt(0), 1'b1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numFails);
        $finish;
    end

endmodule

// File: doc/sobel_result_packer.md
Name: sobel_result_packer

Overview:
- Sink for the sobel_filter output stream (data_out/valid_out); sits between the filter and the frame writer / host DMA.
- Takes one result byte per valid beat, lane 0 (data_in[7:0]), and packs 16 consecutive bytes into one 128-bit word.
- Buffers packed words in a small FIFO and drives them out on a ready/valid master interface; the final word of each frame is tagged with last.
- The filter cannot be stalled, so FIFO overflow is detected and flagged, never back-pressured.

Parameters:
FIFO_DEPTH, 8, packed-word FIFO entries; power of 2, minimum 2
CNT_W, 32, width of frame pixel counters

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; arms a new frame, latches frame_pixels
frame_pixels  in  CNT_W  number of result bytes in the frame
data_in  in  128  filter output; only [7:0] is consumed
valid_in  in  1  data_in beat valid, no backpressure possible
m_data  out  128  packed word; byte k of the word in bits [8k+7:8k]
m_valid  out  1  m_data/m_last valid
m_ready  in  1  downstream accepts the word when m_valid&m_ready
m_last  out  1  word is the final word of the frame
busy  out  1  frame in progress
done  out  1  one-cycle pulse when the last word is accepted
overflow  out  1  sticky; a packed word was dropped because the FIFO was full
pixel_count  out  CNT_W  bytes accepted in the current frame

Behaviour:
- Reset: FSM=IDLE; FIFO empty; pack register, byte index and pixel_count = 0; m_valid=0, m_last=0, m_data=0, busy=0, done=0, overflow=0. rst mid-frame aborts the frame and discards FIFO contents; no done pulse.
- FSM states: IDLE, RUN, FLUSH, WAIT_DRAIN.
  - IDLE: on start, latch frame_pixels, clear pixel_count, byte index and overflow.
    - frame_pixels=0: pulse done next cycle, stay in IDLE, emit no words.
    - Otherwise go to RUN; busy=1 from the next cycle.
  - RUN: each cycle with valid_in=1, write data_in[7:0] into byte lane idx, increment idx (mod 16) and pixel_count.
    - When idx=15 or pixel_count+1=frame_pixels, push the word to the FIFO in the same edge.
    - Unfilled lanes are 0. last=1 if this is the final byte.
    - After the final byte go to WAIT_DRAIN.
  - FLUSH: reserved encoding, never entered; decodes to IDLE.
  - WAIT_DRAIN: ignore valid_in. When a word with last=1 is popped, pulse done for one cycle, drop busy the same cycle, go to IDLE.
- valid_in in IDLE or WAIT_DRAIN is ignored and not counted.
- start while busy=1 is ignored.
- Latency: m_valid rises on the cycle after the edge that samples the 16th (or final) byte, provided the FIFO was empty.
- FIFO:
  - Push and pop in the same cycle are both performed, including when the FIFO is full (the pop frees the slot).
  - Push while full with no pop drops the word and sets overflow. pixel_count still advances.
  - If the dropped word carries last=1, the FSM returns to IDLE with done pulsed immediately, so the frame still terminates.
- Output: m_data, m_last and m_valid are held stable while m_valid=1 and m_ready=0.
- Pointers wrap modulo FIFO_DEPTH. The full/empty distinction uses one extra pointer bit.

Test Plan:
- start, frame_pixels=32; 32 consecutive beats, byte i=i; m_ready=1 → two words: 0x0F0E..0100 (last=0) then 0x1F1E..1110 (last=1); done pulses 1 cycle after the second handshake; pixel_count=32.
- frame_pixels=20, bytes 0xA0+i → word 2 holds bytes 0xB0..0xB3 in lanes 0-3, lanes 4-15 zero, last=1.
- frame_pixels=16×(FIFO_DEPTH+2), m_ready=0 throughout → exactly FIFO_DEPTH words retained, overflow=1; later m_ready=1 → those FIFO_DEPTH words drain in order; terminating done as specified.
- Gapped valid_in (1 beat every 3 cycles) and random m_ready stalls, frame_pixels=48 → byte-identical output to the gapless run; m_data stable while stalled.
- start with frame_pixels=0 → done pulse next cycle, m_valid never asserted. Second start while busy → ignored, frame_pixels unchanged.
- rst asserted after 10 of 32 bytes → all outputs at reset values next cycle. A new frame of 16 bytes then produces one correct word with last=1.
